// File: rtl/calc_display_pkg.sv
// Shared constants for the calculator display blocks: active-low glyphs
// ({g,f,e,d,c,b,a}), special digit codes and the scan FSM state type.
package calc_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to active-low 7-segment decoder; blank forces all
// segments off. Shared by the display blocks.
module seg7_decoder
  import calc_display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (code)
        4'h0:       seg = SEG_0;
        4'h1:       seg = SEG_1;
        4'h2:       seg = SEG_2;
        4'h3:       seg = SEG_3;
        4'h4:       seg = SEG_4;
        4'h5:       seg = SEG_5;
        4'h6:       seg = SEG_6;
        4'h7:       seg = SEG_7;
        4'h8:       seg = SEG_8;
        4'h9:       seg = SEG_9;
        CODE_MINUS: seg = SEG_MINUS;
        CODE_BLANK: seg = SEG_OFF;
        default:    seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed common-anode 7-seg scanner: tick divider, blank-then-drive step
// FSM, frame-synchronous double buffer and leading-zero suppression.
module seg_scan_controller
  import calc_display_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 500,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clock50,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    zero_supp,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    tick,
  output logic                    frame_done
);

  localparam int unsigned DIV_COUNT = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W     = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

  logic [DIV_W-1:0]                 div_cnt;
  logic [BLK_W-1:0]                 blank_cnt;
  logic [IDX_W-1:0]                 idx;
  scan_state_t                      state;
  logic [NUM_DIGITS-1:0][3:0]       disp_reg;
  logic [NUM_DIGITS-1:0][3:0]       pend_reg;
  logic                             pend_vld;
  logic [NUM_DIGITS-1:0]            nonzero;
  logic                             supp;
  logic [6:0]                       dec_seg;

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_done = tick && (idx == IDX_LAST);

  always_ff @(posedge clock50) begin
    if (reset || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // A digit is a leading zero when it and every higher digit are code 0.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign nonzero[g] = |disp_reg[g];
  end

  assign supp = zero_supp && (idx != '0) && ((nonzero >> idx) == '0);

  seg7_decoder u_dec (
    .code  (disp_reg[idx]),
    .blank (supp),
    .seg   (dec_seg)
  );

  // Outputs are sampled from the current state/idx, so they trail the FSM by
  // one cycle. blank_cnt parks at its terminal value while waiting to drive.
  always_ff @(posedge clock50) begin
    if (reset) begin
      state     <= ST_BLANK;
      blank_cnt <= '0;
      idx       <= '0;
      seg_out   <= SEG_OFF;
      an_out    <= '1;
    end else begin
      if (state == ST_DRIVE) begin
        an_out  <= ~(NUM_DIGITS'(1) << idx);
        seg_out <= dec_seg;
      end else begin
        an_out  <= '1;
        seg_out <= SEG_OFF;
      end

      if (tick) begin
        state     <= ST_BLANK;
        blank_cnt <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else if (state == ST_BLANK) begin
        if (blank_cnt == BLK_LAST) begin
          state <= ST_DRIVE;
        end else begin
          blank_cnt <= blank_cnt + BLK_W'(1);
        end
      end
    end
  end

  // A load landing on the commit cycle bypasses the pending buffer.
  always_ff @(posedge clock50) begin
    if (reset) begin
      disp_reg <= '0;
      pend_reg <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (load) begin
        pend_reg <= digits_in;
      end
      if (frame_done) begin
        if (load) begin
          disp_reg <= digits_in;
        end else if (pend_vld) begin
          disp_reg <= pend_reg;
        end
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: scenario tasks plus randomized traffic,
// compared against a time-based behavioural model of the scanned display.
module tb_seg_scan_controller;

  localparam int unsigned CLK_HZ       = 1000;
  localparam int unsigned TICK_HZ      = 100;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned DIV          = CLK_HZ / TICK_HZ;
  localparam int unsigned FRAME        = DIV * NUM_DIGITS;

  logic        clock50   = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load      = 1'b0;
  logic        zero_supp = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        tick;
  logic        frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  seg_scan_controller #(
    .CLK_HZ       (CLK_HZ),
    .TICK_HZ      (TICK_HZ),
    .NUM_DIGITS   (NUM_DIGITS),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock50    (clock50),
    .reset      (reset),
    .digits_in  (digits_in),
    .load       (load),
    .zero_supp  (zero_supp),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .tick       (tick),
    .frame_done (frame_done)
  );

  always #5 clock50 = ~clock50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

  // Reference model: m_n counts cycles since reset. Every DIV cycles a new step
  // starts; its first BLANK_CYCLES cycles are dark, then digit (step mod N)
  // lights. The visible outputs show the previous cycle's situation.
  int unsigned m_n = 0;
  int          m_p, m_k, m_hi;
  bit          m_pvld = 0;
  logic [3:0]  m_disp [NUM_DIGITS];
  logic [3:0]  m_pend [NUM_DIGITS];
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an  = 4'hF;
  logic        exp_tick, exp_fd;

  assign exp_tick = ((m_n % DIV) == (DIV - 1));
  assign exp_fd   = ((m_n % FRAME) == (FRAME - 1));

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  always @(posedge clock50) begin
    if (reset) begin
      m_n = 0;
      m_pvld = 0;
      exp_seg = 7'h7F;
      exp_an = 4'hF;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        m_disp[j] = 4'h0;
        m_pend[j] = 4'h0;
      end
    end else begin
      m_p = int'(m_n % DIV);
      m_k = int'((m_n / DIV) % NUM_DIGITS);
      exp_an = 4'hF;
      exp_seg = 7'h7F;
      if (m_p >= int'(BLANK_CYCLES)) begin
        exp_an = ~(4'(1) << m_k);
        m_hi = -1;
        for (int j = 0; j < NUM_DIGITS; j++)
          if (m_disp[j] != 4'h0) m_hi = j;
        if (!(zero_supp && m_k > 0 && m_k > m_hi)) exp_seg = ref_glyph(m_disp[m_k]);
      end
      if (load)
        for (int j = 0; j < NUM_DIGITS; j++) m_pend[j] = 4'(digits_in >> (4 * j));
      if (exp_fd) begin
        if (load) begin
          for (int j = 0; j < NUM_DIGITS; j++) m_disp[j] = 4'(digits_in >> (4 * j));
        end else if (m_pvld) begin
          for (int j = 0; j < NUM_DIGITS; j++) m_disp[j] = m_pend[j];
        end
        m_pvld = 0;
      end else if (load) begin
        m_pvld = 1;
      end
      m_n++;
    end
  end

  task automatic pulse_load(input logic [15:0] d);
    digits_in = d;
    load = 1'b1;
    @(negedge clock50);
    load = 1'b0;
  endtask

  // Records the next cnt dark-to-lit anode transitions (optionally only after
  // the next frame_done); newest entry lands in the low bits.
  task automatic capture(input bit after_fd, input int cnt,
                         output logic [15:0] ans, output logic [27:0] segs, output bit ok);
    logic [3:0] prev;
    int got;
    bit armed;
    ans = '0;
    segs = '0;
    got = 0;
    armed = !after_fd;
    prev = an_out;
    for (int i = 0; i < 3 * FRAME && got < cnt; i++) begin
      @(negedge clock50);
      if (!armed && frame_done === 1'b1) begin
        armed = 1;
      end else if (armed && prev == 4'hF && an_out != 4'hF) begin
        ans = {ans[11:0], an_out};
        segs = {segs[20:0], seg_out};
        got++;
      end
      prev = an_out;
    end
    ok = (got == cnt);
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1;
    repeat (3) @(posedge clock50);
    @(negedge clock50);
    tests_run++;
    if (seg_out !== 7'h7F || an_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_outputs: seg=%h an=%h, expected seg=7f an=f", seg_out, an_out);
    end
    tests_run++;
    if (tick !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: tick=%b frame_done=%b, expected 0 0", tick, frame_done);
    end
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 3 * int'(DIV) && first == 0; i++) begin
      @(negedge clock50);
      if (tick === 1'b1) first = i + 1;
    end
    tests_run++;
    if (first != 10) begin
      tests_failed++;
      $display("FAIL first_tick: tick seen on cycle %0d, expected cycle 10", first);
    end
  endtask

  task automatic test_scan_order();
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok;
    int last_fd;
    zero_supp = 1'b0;
    pulse_load(16'h1234);
    last_fd = -1;
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      @(negedge clock50);
      tests_run++;
      if (seg_out !== exp_seg || an_out !== exp_an) begin
        tests_failed++;
        $display("FAIL scan_model n=%0d: seg/an=%h/%h, expected %h/%h", m_n, seg_out, an_out, exp_seg, exp_an);
      end
      tests_run++;
      if (tick !== exp_tick || frame_done !== exp_fd) begin
        tests_failed++;
        $display("FAIL scan_pulses n=%0d: tick/fd=%b%b, expected %b%b", m_n, tick, frame_done, exp_tick, exp_fd);
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          tests_run++;
          if (i - last_fd != int'(FRAME)) begin
            tests_failed++;
            $display("FAIL fd_period: %0d cycles between frame_done, expected %0d", i - last_fd, FRAME);
          end
        end
        last_fd = i;
      end
    end
    capture(1, 4, ans, segs, ok);
    tests_run++;
    if (!ok || ans !== 16'hEDB7 || segs !== {7'h19, 7'h30, 7'h24, 7'h79}) begin
      tests_failed++;
      $display("FAIL scan_order: ok=%b an seq=%h segs=%h, expected an seq=edb7 segs=%h",
               ok, ans, segs, {7'h19, 7'h30, 7'h24, 7'h79});
    end
  endtask

  task automatic test_no_tearing();
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok, found;
    found = 0;
    for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
      @(negedge clock50);
      found = (an_out === 4'hD);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL tear_wait: an_out=d not seen, expected within %0d cycles", 2 * FRAME);
    end
    pulse_load(16'h5678);
    capture(0, 2, ans, segs, ok);
    tests_run++;
    if (!ok || ans[7:0] !== 8'hB7 || segs[13:0] !== {7'h24, 7'h79}) begin
      tests_failed++;
      $display("FAIL tear_old: ok=%b an=%h segs=%h, expected an=b7 segs=%h", ok, ans[7:0], segs[13:0], {7'h24, 7'h79});
    end
    capture(1, 4, ans, segs, ok);
    tests_run++;
    if (!ok || ans !== 16'hEDB7 || segs !== {7'h00, 7'h78, 7'h02, 7'h12}) begin
      tests_failed++;
      $display("FAIL tear_new: ok=%b an=%h segs=%h, expected an=edb7 segs=%h", ok, ans, segs, {7'h00, 7'h78, 7'h02, 7'h12});
    end
  endtask

  task automatic test_last_wins();
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok, found;
    found = 0;
    for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
      @(negedge clock50);
      found = (frame_done === 1'b1);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL last_wins_wait: frame_done not seen, expected within %0d cycles", 2 * FRAME);
    end
    repeat (3) @(negedge clock50);
    pulse_load(16'h1111);
    repeat (10) @(negedge clock50);
    pulse_load(16'h2222);
    capture(1, 4, ans, segs, ok);
    tests_run++;
    if (!ok || segs !== {4{7'h24}}) begin
      tests_failed++;
      $display("FAIL last_wins: ok=%b segs=%h, expected %h", ok, segs, {4{7'h24}});
    end
  endtask

  task automatic test_bypass();
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok, found;
    found = 0;
    for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
      @(negedge clock50);
      found = (frame_done === 1'b1);
    end
    repeat (5) @(negedge clock50);
    pulse_load(16'h4444);
    found = 0;
    for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
      @(negedge clock50);
      found = (frame_done === 1'b1);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL bypass_wait: frame_done not seen, expected within %0d cycles", 2 * FRAME);
    end
    pulse_load(16'h9999);
    tests_run++;
    if (dut.pend_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_pend_vld: pend_vld=%b, expected 0", dut.pend_vld);
    end
    capture(0, 1, ans, segs, ok);
    tests_run++;
    if (!ok || ans[3:0] !== 4'hE || segs[6:0] !== 7'h10) begin
      tests_failed++;
      $display("FAIL bypass_first: ok=%b an=%h seg=%h, expected an=e seg=10", ok, ans[3:0], segs[6:0]);
    end
    capture(1, 1, ans, segs, ok);
    tests_run++;
    if (!ok || segs[6:0] !== 7'h10) begin
      tests_failed++;
      $display("FAIL bypass_next_frame: ok=%b seg=%h, expected seg=10", ok, segs[6:0]);
    end
  endtask

  task automatic test_zero_supp();
    logic [15:0] pats [2];
    logic [27:0] want [2];
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok;
    pats[0] = 16'h00A7;
    want[0] = {7'h78, 7'h3F, 7'h7F, 7'h7F};
    pats[1] = 16'h0000;
    want[1] = {7'h40, 7'h7F, 7'h7F, 7'h7F};
    zero_supp = 1'b1;
    for (int t = 0; t < 2; t++) begin
      pulse_load(pats[t]);
      capture(1, 4, ans, segs, ok);
      tests_run++;
      if (!ok || ans !== 16'hEDB7 || segs !== want[t]) begin
        tests_failed++;
        $display("FAIL zero_supp %h: ok=%b an=%h segs=%h, expected an=edb7 segs=%h", pats[t], ok, ans, segs, want[t]);
      end
    end
  endtask

  task automatic test_random_traffic();
    logic [15:0] mask;
    for (int i = 0; i < 8 * int'(FRAME); i++) begin
      @(negedge clock50);
      tests_run++;
      if (seg_out !== exp_seg || an_out !== exp_an) begin
        tests_failed++;
        $display("FAIL rand_model n=%0d: seg/an=%h/%h, expected %h/%h", m_n, seg_out, an_out, exp_seg, exp_an);
      end
      tests_run++;
      if (tick !== exp_tick || frame_done !== exp_fd) begin
        tests_failed++;
        $display("FAIL rand_pulses n=%0d: tick/fd=%b%b, expected %b%b", m_n, tick, frame_done, exp_tick, exp_fd);
      end
      mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
      digits_in = 16'($urandom) & mask;
      load = ($urandom_range(0, 11) == 0) || (frame_done === 1'b1 && $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 47) == 0) zero_supp = ~zero_supp;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    logic [15:0] ans;
    logic [27:0] segs;
    bit ok, found;
    found = 0;
    for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
      @(negedge clock50);
      found = (an_out === 4'hB);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL mid_reset_wait: an_out=b not seen, expected within %0d cycles", 2 * FRAME);
    end
    reset = 1'b1;
    @(negedge clock50);
    tests_run++;
    if (seg_out !== 7'h7F || an_out !== 4'hF || tick !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: seg=%h an=%h tick=%b fd=%b, expected 7f f 0 0", seg_out, an_out, tick, frame_done);
    end
    reset = 1'b0;
    zero_supp = 1'b1;
    capture(0, 1, ans, segs, ok);
    tests_run++;
    if (!ok || ans[3:0] !== 4'hE || segs[6:0] !== 7'h40) begin
      tests_failed++;
      $display("FAIL mid_reset_restart: ok=%b an=%h seg=%h, expected an=e seg=40", ok, ans[3:0], segs[6:0]);
    end
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      @(negedge clock50);
      tests_run++;
      if (seg_out !== exp_seg || an_out !== exp_an || tick !== exp_tick || frame_done !== exp_fd) begin
        tests_failed++;
        $display("FAIL mid_reset_model n=%0d: seg/an/tick/fd=%h/%h/%b/%b, expected %h/%h/%b/%b",
                 m_n, seg_out, an_out, tick, frame_done, exp_seg, exp_an, exp_tick, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_no_tearing();
    test_last_wins();
    test_bypass();
    test_zero_supp();
    test_random_traffic();
    test_reset_mid_drive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
